reg_file32: RTL

32 x 32-bit general-purpose register file for the single-cycle/multicycle datapath. It sits directly upstream of the 32-bit ALU and drives its op1/op2 operands from two asynchronous read ports. It takes the ALU result (or memory data, via an external mux) back on one synchronous write port. It also holds a 3-bit status register (V, N, Z), loaded from the ALU flag outputs, for branch decisions.

---
 rtl/reg_file32.sv | 112 +++++++++++
 1 files changed

// File: rtl/reg_file32.sv
// -----------------------------------------------------------------------------
// reg_file32
//
// General-purpose register file for the 32-bit datapath. It provides two
// combinational read ports that drive the ALU operands, one synchronous write
// port for the ALU/memory result, and a 3-bit status register (V, N, Z) that is
// loaded from the ALU flag outputs for branch decisions.
//
// There is no valid/ready handshake on this block. Every control input is a
// plain per-cycle enable: reg_write and flag_write are sampled at each rising
// edge, and the read ports are purely combinational with no flow control.
//
// Ports:
//   clk         in   rising-edge clock for all state
//   reset       in   synchronous, active-high; clears registers and flags
//   read_reg1   in   index for read port 1 (ALU op1)
//   read_reg2   in   index for read port 2 (ALU op2)
//   read_data1  out  combinational read data, port 1
//   read_data2  out  combinational read data, port 2
//   write_reg   in   destination index
//   write_data  in   value to write
//   reg_write   in   register write enable
//   flag_write  in   status register load enable
//   v_in        in   overflow flag from the ALU
//   n_in        in   negative flag from the ALU
//   z_in        in   zero flag from the ALU
//   v_flag      out  registered overflow flag
//   n_flag      out  registered negative flag
//   z_flag      out  registered zero flag
// -----------------------------------------------------------------------------
module reg_file32 #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int BYPASS     = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] read_reg1,
    input  logic [ADDR_WIDTH-1:0] read_reg2,
    output logic [DATA_WIDTH-1:0] read_data1,
    output logic [DATA_WIDTH-1:0] read_data2,
    input  logic [ADDR_WIDTH-1:0] write_reg,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  reg_write,
    input  logic                  flag_write,
    input  logic                  v_in,
    input  logic                  n_in,
    input  logic                  z_in,
    output logic                  v_flag,
    output logic                  n_flag,
    output logic                  z_flag
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    // A write is only real when the destination is not the hardwired zero
    // register; this same qualifier gates both storage and forwarding.
    logic write_hit;
    assign write_hit = reg_write && (write_reg != '0);

    // Storage array. Entry 0 is cleared by reset and never written, but the
    // read path forces zero for index 0 anyway so its contents never matter.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (write_hit) begin
            regs[write_reg] <= write_data;
        end
    end

    // Status register. Flags are never forwarded; the outputs always show the
    // value captured at the last load.
    always_ff @(posedge clk) begin
        if (reset) begin
            v_flag <= 1'b0;
            n_flag <= 1'b0;
            z_flag <= 1'b0;
        end else if (flag_write) begin
            v_flag <= v_in;
            n_flag <= n_in;
            z_flag <= z_in;
        end
    end

    // Forwarding is disabled while reset is asserted: the write in that cycle
    // is dropped, so returning write_data would expose a value never stored.
    logic bypass_en;
    assign bypass_en = (BYPASS != 0) && !reset && write_hit;

    always_comb begin
        read_data1 = regs[read_reg1];
        if (read_reg1 == '0) begin
            read_data1 = '0;
        end else if (bypass_en && (write_reg == read_reg1)) begin
            read_data1 = write_data;
        end
    end

    always_comb begin
        read_data2 = regs[read_reg2];
        if (read_reg2 == '0) begin
            read_data2 = '0;
        end else if (bypass_en && (write_reg == read_reg2)) begin
            read_data2 = write_data;
        end
    end

endmodule
